// File: rtl/dtgen_xloop_xcontrol_xu20_xu5.sv
// Dead-time / non-overlap gate generator: turns the PWM request into HS/LS gate
// commands with programmable dead time, HS minimum on-time, OCP abort and ZCD.
module dtgen_xloop_xcontrol_xu20_xu5 #(
    parameter int DT_W    = 6,
    parameter int MINON_W = 6,
    parameter int OCPC_W  = 8
) (
    input  logic               CELCLK,
    input  logic               CELRSTN,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    input  logic               en_i,
    input  logic               pwm_i,
    input  logic [DT_W-1:0]    dt_lh_i,
    input  logic [DT_W-1:0]    dt_hl_i,
    input  logic [MINON_W-1:0] min_on_i,
    input  logic               ocp_i,
    input  logic               zcd_i,
    output logic               hs_o,
    output logic               ls_o,
    output logic               ocp_lock_o,
    output logic [OCPC_W-1:0]  ocp_cnt_o
);
    localparam int CNT_W = (DT_W > MINON_W) ? DT_W : MINON_W;

    typedef enum logic [2:0] {IDLE, DTLH, HS_ON, DTHL, LS_ON} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                ocp_lock, ocp_lock_nx;
    logic [OCPC_W-1:0]   ocp_cnt, ocp_cnt_nx;
    logic                hs_q, ls_q;

    // Supply/substrate pins carry no logic.
    logic unused_pwr;
    assign unused_pwr = &{1'b0, CELV, CELG, SUB};

    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state    <= IDLE;
            cnt      <= '0;
            ocp_lock <= 1'b0;
            ocp_cnt  <= '0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ocp_lock <= ocp_lock_nx;
            ocp_cnt  <= ocp_cnt_nx;
            hs_q     <= (state_nx == HS_ON);
            ls_q     <= (state_nx == LS_ON);
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ocp_lock_nx = ocp_lock;
        ocp_cnt_nx  = ocp_cnt;

        // Lock release is independent of state and enable; it can never
        // coincide with an abort because an abort needs ocp_i=1.
        if (!pwm_i && !ocp_i)
            ocp_lock_nx = 1'b0;

        if (!en_i) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pwm_i && !ocp_lock) begin
                        state_nx = DTLH;
                        cnt_nx   = CNT_W'(dt_lh_i);
                    end
                end
                DTLH: begin
                    if (ocp_i) begin
                        state_nx = IDLE;
                    end else if (cnt == '0) begin
                        state_nx = HS_ON;
                        cnt_nx   = CNT_W'(min_on_i);
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                HS_ON: begin
                    if (ocp_i) begin
                        state_nx    = DTHL;
                        cnt_nx      = CNT_W'(dt_hl_i);
                        ocp_lock_nx = 1'b1;
                        if (ocp_cnt != '1)
                            ocp_cnt_nx = ocp_cnt + OCPC_W'(1);
                    end else if (!pwm_i && cnt == '0) begin
                        state_nx = DTHL;
                        cnt_nx   = CNT_W'(dt_hl_i);
                    end else if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                DTHL: begin
                    if (cnt == '0)
                        state_nx = LS_ON;
                    else
                        cnt_nx = cnt - CNT_W'(1);
                end
                LS_ON: begin
                    // A new PWM request wins over diode emulation.
                    if (pwm_i && !ocp_lock) begin
                        state_nx = DTLH;
                        cnt_nx   = CNT_W'(dt_lh_i);
                    end else if (zcd_i) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign hs_o       = hs_q;
    assign ls_o       = ls_q;
    assign ocp_lock_o = ocp_lock;
    assign ocp_cnt_o  = ocp_cnt;

endmodule

// File: tb/tb_dtgen_xloop_xcontrol_xu20_xu5.sv
// Randomized + directed bench for the dead-time generator, checked every cycle
// against an elapsed-time reference model.
module tb_dtgen_xloop_xcontrol_xu20_xu5;
    logic       clk = 0;
    logic       rstn = 0;
    logic       en = 0, pwm = 0, ocp = 0, zcd = 0;
    logic [5:0] dt_lh = 3, dt_hl = 2, min_on = 4;
    logic       hs, ls, lock;
    logic [7:0] ocnt;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    dtgen_xloop_xcontrol_xu20_xu5 #(.DT_W(6), .MINON_W(6), .OCPC_W(8)) dut (
        .CELCLK(clk), .CELRSTN(rstn), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en_i(en), .pwm_i(pwm), .dt_lh_i(dt_lh), .dt_hl_i(dt_hl), .min_on_i(min_on),
        .ocp_i(ocp), .zcd_i(zcd), .hs_o(hs), .ls_o(ls), .ocp_lock_o(lock), .ocp_cnt_o(ocnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases tracked by elapsed cycles rather than countdowns.
    // to_hs/to_ls mark a both-low gap heading towards HS or LS.
    bit m_hs, m_ls, m_to_hs, m_to_ls, m_lock;
    int m_low, m_gap, m_hon, m_min, m_ocnt;

    task automatic model_step();
        bit nlock;
        if (!rstn) begin
            m_hs = 0; m_ls = 0; m_to_hs = 0; m_to_ls = 0; m_lock = 0; m_ocnt = 0;
            return;
        end
        nlock = (!pwm && !ocp) ? 1'b0 : m_lock;
        if (!en) begin
            m_hs = 0; m_ls = 0; m_to_hs = 0; m_to_ls = 0;
        end else if (m_hs) begin
            if (ocp) begin
                m_hs = 0; m_to_ls = 1; m_low = 1; m_gap = dt_hl + 1; nlock = 1;
                m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : 255;
            end else if (!pwm && m_hon >= m_min + 1) begin
                m_hs = 0; m_to_ls = 1; m_low = 1; m_gap = dt_hl + 1;
            end else m_hon++;
        end else if (m_to_hs) begin
            if (ocp) m_to_hs = 0;
            else if (m_low >= m_gap) begin
                m_to_hs = 0; m_hs = 1; m_hon = 1; m_min = min_on;
            end else m_low++;
        end else if (m_to_ls) begin
            if (m_low >= m_gap) begin m_to_ls = 0; m_ls = 1; end
            else m_low++;
        end else if (pwm && !m_lock) begin
            m_ls = 0; m_to_hs = 1; m_low = 1; m_gap = dt_lh + 1;
        end else if (m_ls && zcd) begin
            m_ls = 0;
        end
        m_lock = nlock;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hs", hs, m_hs);
            chk("ls", ls, m_ls);
            chk("lock", lock, m_lock);
            chk("ocp_cnt", ocnt, m_ocnt);
            chk("overlap", hs & ls, 0);
        end
    end

    task automatic step(input logic p, input logic o, input logic z);
        @(posedge clk); #2;
        pwm = p; ocp = o; zcd = z;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Drive pwm until the model reaches HS (sel=0) or LS (sel=1).
    task automatic wait_for(input int sel, input logic p);
        int k;
        k = 0;
        while (((sel == 0) ? !m_hs : !m_ls) && k < 200) begin
            step(p, 0, 0);
            k++;
        end
        if (k >= 200) chk("timeout", 0, 1);
    endtask

    initial begin
        en = 1;
        step(0, 0, 0); step(0, 0, 0);
        #1 chk_on = 1;
        step(0, 0, 0);
        rstn = 1;

        // 10-cycle and 2-cycle pulses
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        idle(25);
        for (int i = 0; i < 2; i++) step(1, 0, 0);
        idle(20);

        // OCP abort in 2nd HS cycle, lock blocks re-entry while pwm stays high
        wait_for(0, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        #1 chk("ocp_cnt1", ocnt, 1);
        chk("ocp_lock1", lock, 1);
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        idle(20);

        // ZCD alone, then ZCD coinciding with a new request
        wait_for(1, 0);
        step(0, 0, 1); step(0, 0, 0);
        idle(3);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        wait_for(1, 0);
        step(1, 0, 1); step(0, 0, 0);
        idle(20);

        // enable drop in HS_ON, reset in LS_ON
        wait_for(0, 1);
        en = 0; step(1, 0, 0);
        #4 chk("en_drop_hs", hs, 0);
        en = 1; idle(3);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        wait_for(1, 0);
        rstn = 0; step(0, 0, 0);
        #4 chk("rst_ls", ls, 0);
        chk("rst_cnt", ocnt, 0);
        rstn = 1; idle(2);

        // 300 aborts with zero dead time
        dt_lh = 0; dt_hl = 0; min_on = 1;
        for (int n = 0; n < 300; n++) begin
            wait_for(0, 1);
            step(1, 1, 0);
            step(0, 0, 0); step(0, 0, 0);
        end
        idle(5);
        #1 chk("ocp_sat", ocnt, 255);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                dt_lh  = ($urandom_range(0, 9) == 0) ? 6'h3f : 6'($urandom_range(0, 5));
                dt_hl  = 6'($urandom_range(0, 5));
                min_on = 6'($urandom_range(0, 7));
            end
            en   = ($urandom_range(0, 99) != 0);
            rstn = ($urandom_range(0, 499) != 0);
            step(($urandom_range(0, 9) < 5) ? pwm : ~pwm,
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        rstn = 1; en = 1;
        idle(5);
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
